uart_rx_word_assembler: RTL and testbench

- Upstream counterpart of the 32-to-8 transmit serializer. Collects four consecutive bytes from the UART receiver (rx_data/rx_done) and packs them MSB-first into one 32-bit word.
- Presents the word to the processor-trainer core through a valid/ready handshake.
- Fully synchronous to sys_clk. An inter-byte timeout resynchronises word framing after a lost byte.

---
 rtl/uart_rx_word_assembler.sv | 134 +++++++++++++
 tb/tb_uart_rx_word_assembler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_assembler.sv
// Packs four UART receive bytes MSB-first into a 32-bit word behind a valid/ready
// output register, with an inter-byte timeout and a sticky overrun flag.
module uart_rx_word_assembler #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        word_ready,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic [1:0]  byte_idx,
  output logic        overrun,
  output logic        timeout_err
);

  typedef enum logic {ASM_IDLE = 1'b0, ASM_COLLECT = 1'b1} asm_state_e;

  // Expiry is decided one count early so the discard lands on the edge where
  // the counter would have reached TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 2);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             done_prev_q, done_prev_d;
  logic             stb_q, stb_d;
  asm_state_e       state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      asm_q, asm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  logic             expire;
  logic             complete;
  logic [31:0]      new_word;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    sync1_d       = rx_done;
    sync2_d       = sync1_q;
    done_prev_d   = sync2_q;
    stb_d         = sync2_q & ~done_prev_q;
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    cnt_d         = '0;
    word_d        = word_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;
    timeout_err_d = 1'b0;
    complete      = 1'b0;
    new_word      = {asm_q, rx_data};
    expire        = (state_q == ASM_COLLECT) && (cnt_q == EXPIRE_AT);

    if (state_q == ASM_COLLECT && !expire && !stb_q) cnt_d = cnt_q + CNT_W'(1);

    if (expire) begin
      state_d       = ASM_IDLE;
      byte_idx_d    = 2'd0;
      timeout_err_d = 1'b1;
    end

    if (stb_q) begin
      if (expire || state_q == ASM_IDLE) begin
        // A byte arriving on the expiry edge starts a fresh word.
        asm_d[23:16] = rx_data;
        byte_idx_d   = 2'd1;
        state_d      = ASM_COLLECT;
      end else begin
        case (byte_idx_q)
          2'd1:    asm_d[15:8] = rx_data;
          2'd2:    asm_d[7:0]  = rx_data;
          default: complete    = 1'b1;
        endcase
        byte_idx_d = byte_idx_q + 2'd1;
        if (complete) state_d = ASM_IDLE;
      end
    end

    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = new_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      done_prev_q   <= 1'b0;
      stb_q         <= 1'b0;
      state_q       <= ASM_IDLE;
      byte_idx_q    <= 2'd0;
      asm_q         <= '0;
      cnt_q         <= '0;
      word_q        <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      done_prev_q   <= done_prev_d;
      stb_q         <= stb_d;
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign byte_idx    = byte_idx_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Bench for uart_rx_word_assembler: directed table, hand-written corner sequences
// and random byte traffic checked every cycle against a byte-queue model.
module tb_uart_rx_word_assembler;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        word_ready = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic [1:0]  byte_idx;
  logic        overrun;
  logic        timeout_err;

  uart_rx_word_assembler #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .sys_clk    (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .byte_idx   (byte_idx),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs as seen by the active edge, consumed by the model half a cycle later.
  logic       s_reset = 1'b1;
  logic       s_done = 1'b0;
  logic       s_ready = 1'b0;
  logic [7:0] s_data = '0;
  always @(posedge clk) begin
    s_reset <= reset;
    s_done  <= rx_done;
    s_ready <= word_ready;
    s_data  <= rx_data;
  end

  // Reference model: a byte is accepted three edges after rx_done is first seen
  // high; bytes gather in a queue, four of them form a word.
  logic [3:0]  hist = '0;
  logic [7:0]  part[$];
  int          idle = 0;
  logic [31:0] m_word = '0;
  logic        m_valid = 1'b0;
  logic        m_overrun = 1'b0;
  logic        m_err = 1'b0;
  logic        m_live = 1'b0;

  int n_valid_cyc = 0;
  int last_rise_cyc = -1;
  int n_err = 0;
  int last_err_cyc = -1;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    logic        stb;
    logic        done_word;
    logic [31:0] nw;
    if (!s_reset) begin
      hist = '0;
      part.delete();
      idle = 0;
      m_word = '0;
      m_valid = 1'b0;
      m_overrun = 1'b0;
      m_err = 1'b0;
      m_live = 1'b1;
    end else begin
      stb = hist[2] & ~hist[3];
      hist = {hist[2:0], s_done};
      m_err = 1'b0;
      done_word = 1'b0;
      nw = '0;
      if (part.size() > 0) begin
        idle++;
        if (idle == TO - 1) begin
          part.delete();
          idle = 0;
          m_err = 1'b1;
        end
      end
      if (stb) begin
        idle = 0;
        if (part.size() == 3) begin
          nw = {part[0], part[1], part[2], s_data};
          part.delete();
          done_word = 1'b1;
        end else begin
          part.push_back(s_data);
        end
      end
      if (done_word) begin
        if (!m_valid || s_ready) begin
          m_word = nw;
          m_valid = 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end else if (m_valid && s_ready) begin
        m_valid = 1'b0;
      end
    end
    if (m_live) begin
      check("model_word_out", word_out, m_word);
      check("model_word_valid", 32'(word_valid), 32'(m_valid));
      check("model_byte_idx", 32'(byte_idx), 32'(part.size()));
      check("model_overrun", 32'(overrun), 32'(m_overrun));
      check("model_timeout_err", 32'(timeout_err), 32'(m_err));
    end
    if (word_valid === 1'b1) begin
      n_valid_cyc++;
      if (!prev_valid) last_rise_cyc = cyc;
    end
    prev_valid = (word_valid === 1'b1);
    if (timeout_err === 1'b1) begin
      n_err++;
      last_err_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rc returns the edge count at which rx_done was raised; the byte is taken
  // four edges later, and rx_data is held until the next call.
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap, output int rc);
    rx_data = b;
    rx_done = 1'b1;
    rc = cyc;
    repeat (hold) tick();
    rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int hold);
    int rc;
    for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8], hold, 5, rc);
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          hold;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[4];
  logic rdone = 1'b0;

  initial begin
    int rc, rc4, v0, e0;
    logic [31:0] w;

    vecs[0] = '{bytes: 32'hDEADBEEF, hold: 1,  exp_word: 32'hDEADBEEF};
    vecs[1] = '{bytes: 32'h01020304, hold: 10, exp_word: 32'h01020304};
    vecs[2] = '{bytes: 32'h10203040, hold: 3,  exp_word: 32'h10203040};
    vecs[3] = '{bytes: 32'h0BADF00D, hold: 2,  exp_word: 32'h0BADF00D};

    repeat (3) tick();
    @(negedge clk);
    check("rst_word_out", word_out, 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_byte_idx", 32'(byte_idx), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    tick();
    reset = 1'b1;
    word_ready = 1'b1;
    repeat (2) tick();

    // Table: one word per entry, consumer always ready.
    for (int v = 0; v < 4; v++) begin
      v0 = n_valid_cyc;
      w = vecs[v].bytes;
      rc4 = 0;
      for (int j = 0; j < 4; j++) begin
        send_byte(w[31-8*j -: 8], vecs[v].hold, 5, rc);
        if (j == 3) rc4 = rc;
        @(negedge clk);
        check($sformatf("vec%0d_byte_idx%0d", v, j), 32'(byte_idx), 32'((j + 1) % 4));
      end
      check($sformatf("vec%0d_word", v), word_out, vecs[v].exp_word);
      check($sformatf("vec%0d_latency", v), 32'(last_rise_cyc - rc4), 32'd4);
      check($sformatf("vec%0d_valid_cycles", v), 32'(n_valid_cyc - v0), 32'd1);
    end

    // Timeout after two bytes: pulse 19 edges after 0xBB is taken (raise + 4).
    e0 = n_err;
    send_byte(8'hAA, 1, 5, rc);
    send_byte(8'hBB, 1, 5, rc);
    repeat (30) tick();
    @(negedge clk);
    check("to_pulse_count", 32'(n_err - e0), 32'd1);
    check("to_pulse_time", 32'(last_err_cyc - rc), 32'd23);
    check("to_byte_idx", 32'(byte_idx), 32'd0);
    send_word(32'h01020304, 1);
    check("to_next_word", word_out, 32'h01020304);

    // Byte taken on the very expiry edge becomes byte 0 of a new word.
    e0 = n_err;
    send_byte(8'hAA, 1, 18, rc);
    send_byte(8'h55, 1, 5, rc);
    @(negedge clk);
    check("coinc_pulse_count", 32'(n_err - e0), 32'd1);
    check("coinc_byte_idx", 32'(byte_idx), 32'd1);
    send_byte(8'h66, 1, 5, rc);
    send_byte(8'h77, 1, 5, rc);
    send_byte(8'h88, 1, 5, rc);
    check("coinc_word", word_out, 32'h55667788);

    // Back-to-back: completion lands on the same edge the pending word is taken.
    word_ready = 1'b0;
    send_word(32'hCAFEBABE, 1);
    send_byte(8'h0B, 1, 5, rc);
    send_byte(8'hAD, 1, 5, rc);
    send_byte(8'hF0, 1, 5, rc);
    @(negedge clk);
    check("b2b_pending_word", word_out, 32'hCAFEBABE);
    check("b2b_pending_valid", 32'(word_valid), 32'd1);
    rx_data = 8'h0D;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat (2) tick();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    @(negedge clk);
    check("b2b_word", word_out, 32'h0BADF00D);
    check("b2b_valid", 32'(word_valid), 32'd1);
    check("b2b_overrun", 32'(overrun), 32'd0);
    word_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("b2b_drained", 32'(word_valid), 32'd0);

    // Overrun: second word dropped while the first is still pending.
    word_ready = 1'b0;
    send_word(32'h11223344, 2);
    @(negedge clk);
    check("ovr_first_valid", 32'(word_valid), 32'd1);
    check("ovr_first_flag", 32'(overrun), 32'd0);
    send_word(32'h55667788, 2);
    @(negedge clk);
    check("ovr_word_kept", word_out, 32'h11223344);
    check("ovr_valid_kept", 32'(word_valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    word_ready = 1'b1;
    tick();
    @(negedge clk);
    check("ovr_valid_drop", 32'(word_valid), 32'd0);
    check("ovr_word_after", word_out, 32'h11223344);

    // One-cycle reset mid-word.
    send_byte(8'hA1, 1, 5, rc);
    send_byte(8'hA2, 1, 5, rc);
    @(negedge clk);
    check("mid_byte_idx", 32'(byte_idx), 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_word", word_out, 32'h0);
    check("mid_rst_valid", 32'(word_valid), 32'h0);
    check("mid_rst_idx", 32'(byte_idx), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_err", 32'(timeout_err), 32'h0);
    tick();
    send_word(32'h10203040, 1);
    check("mid_next_word", word_out, 32'h10203040);

    // Random traffic with random consumer back-pressure and occasional long gaps.
    rdone = 1'b0;
    fork
      begin
        int rrc, hold, gap;
        for (int i = 0; i < 250; i++) begin
          hold = $urandom_range(1, 4);
          gap = $urandom_range(4, 8);
          if ($urandom_range(0, 7) == 0) gap += $urandom_range(10, 25);
          send_byte(8'($urandom), hold, gap, rrc);
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          tick();
          word_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    word_ready = 1'b1;
    repeat (10) tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
